core_issue: RTL
===============

# core_issue

Operand-issue stage that sits directly in front of `core_execution` and drives its operand, opcode, shift-amount and invert inputs. It accepts decoded instructions, reads the register file and forwards write-back data. A register scoreboard blocks read-after-write hazards. It presents each instruction to the execution stage through a registered valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `SHAMT_WIDTH`, 5, shift-amount width
- `REG_ADDR_WIDTH`, 5, register index width; scoreboard has 2**REG_ADDR_WIDTH entries

Ports:
- `clk_i` in 1 — single clock; all state on rising edge
- `rst_ni` in 1 — reset, asynchronous, active-low
- `dec_valid_i` in 1 — decoded instruction present
- `dec_ready_o` out 1 — stage accepts instruction this cycle
- `dec_rs1_i`, `dec_rs2_i`, `dec_rd_i` in REG_ADDR_WIDTH — source/destination indices
- `dec_rd_we_i` in 1 — instruction writes `dec_rd_i`
- `dec_use_imm_i` in 1 — operand B from immediate, rs2 not read
- `dec_imm_i` in DATA_WIDTH — immediate
- `dec_alu_op_i` in 5, `dec_shamt_i` in SHAMT_WIDTH, `dec_invert_i` in 1 — passed through to execution
- `rf_raddr_a_o`, `rf_raddr_b_o` out REG_ADDR_WIDTH — combinational RF read addresses (= rs1, rs2)
- `rf_rdata_a_i`, `rf_rdata_b_i` in DATA_WIDTH — combinational RF read data
- `wb_valid_i` in 1, `wb_rd_i` in REG_ADDR_WIDTH, `wb_data_i` in DATA_WIDTH — write-back port
- `flush_i` in 1 — kill the instruction held in the issue register
- `ex_valid_o` out 1, `ex_ready_i` in 1 — handshake to execution
- `operands_a_o`, `operands_b_o` out DATA_WIDTH; `alu_op_o` out 5; `shamt_o` out SHAMT_WIDTH; `invert_o` out 1 — execution inputs
- `ex_rd_o` out REG_ADDR_WIDTH, `ex_rd_we_o` out 1 — destination carried to write-back

## Operation
- **Scoreboard:** one busy bit per register. Bit 0 is hardwired 0, so x0 is never busy and always reads 0.
- **Operand forwarding:** source value is selected in priority order:
  - rs == 0 → 0
  - `wb_valid_i` and `wb_rd_i` == rs → `wb_data_i`
  - otherwise → RF data
- **Hazard:**
  - Set when rs1 is busy and not being written back this cycle.
  - Also set when `!dec_use_imm_i`, rs2 is busy and rs2 is not being written back this cycle.
- **Ready:** `dec_ready_o = !hazard && !flush_i && (!ex_valid_o || ex_ready_i)`. It is combinational.
- **Accept** (`dec_valid_i && dec_ready_o`):
  - Load the issue register: A = fwd(rs1); B = `dec_use_imm_i` ? imm : fwd(rs2); op, shamt, invert, rd and rd_we pass through.
  - Set `ex_valid_o` = 1.
  - If `dec_rd_we_i` and rd ≠ 0, set busy[rd].
- **Drain:** `ex_valid_o && ex_ready_i` with no accept clears `ex_valid_o`. Data outputs hold their last value.
- **Write-back:** `wb_valid_i` clears busy[`wb_rd_i`]. If the same cycle sets the same bit through an accept, the set wins.
- **Flush:**
  - Clears `ex_valid_o`.
  - If the flushed instruction had rd_we with rd ≠ 0, clears its busy bit (the set wins over this clear too).
  - No accept occurs in a flush cycle. Other busy bits are untouched.
- **Stall:** while `ex_valid_o && !ex_ready_i`, all issue-register outputs stay stable.
- **Reset:**
  - `ex_valid_o` = 0; all data outputs = 0; all busy bits = 0.
  - `dec_ready_o` evaluates to 1 after reset.

## Timing
- Latency: 1 cycle from accept edge to `ex_valid_o` high with operands.
- Throughput: 1 instruction/cycle when there is no hazard and `ex_ready_i` = 1.
- Back-to-back dependence (rd of N = rs of N+1) stalls instruction N+1 until write-back of rd:
  - In the write-back cycle, N+1 is accepted with forwarded data.
  - N+1 appears on the execution outputs the next cycle.
- `rf_raddr_*_o` follow `dec_rs*_i` combinationally every cycle.
- Reset assertion mid-operation aborts immediately and asynchronously. The first accept is possible on the first edge after deassertion.

## Test plan
- **Independent stream:** after reset, issue ADD x3 ← x1, x2 with RF x1 = 5, x2 = 7, then x4 ← x1 + imm 9, `ex_ready_i` = 1. Expect operands (5, 7), then (5, 9), on consecutive cycles; busy[3] and busy[4] set.
- **RAW stall + forward:** issue x5 ← …, then x6 ← x5. Expect `dec_ready_o` = 0 until `wb_valid_i`/`wb_rd_i` = 5 with `wb_data_i` = 0x1234 arrives. Expect accept in that same cycle with `operands_a_o` = 0x1234 the following cycle.
- **Back-pressure:** hold `ex_ready_i` = 0 for 3 cycles with `ex_valid_o` = 1. Expect all outputs stable and `dec_ready_o` = 0. Release: drain and new accept occur in the same cycle.
- **Simultaneous set/clear:** write-back of x7 coincides with accepting a new instruction writing x7. Expect busy[7] = 1 afterwards.
- **x0 handling:** rd = 0 with rd_we → no busy bit set. rs1 = 0 with RF data 0xFFFF_FFFF → `operands_a_o` = 0.
- **Flush/reset:** flush holding x8 → `ex_valid_o` = 0, busy[8] = 0. Assert `rst_ni` mid-stall → all outputs 0 and `ex_valid_o` = 0 immediately.

Source files
------------

// File: rtl/core_issue_if.sv
// Decode-side and execution-side handshake bundle of the operand-issue stage.
// The issue stage connects through the slave modport; its environment uses master.
interface core_issue_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int SHAMT_WIDTH    = 5,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      dec_valid_i;
    logic                      dec_ready_o;
    logic [REG_ADDR_WIDTH-1:0] dec_rs1_i;
    logic [REG_ADDR_WIDTH-1:0] dec_rs2_i;
    logic [REG_ADDR_WIDTH-1:0] dec_rd_i;
    logic                      dec_rd_we_i;
    logic                      dec_use_imm_i;
    logic [DATA_WIDTH-1:0]     dec_imm_i;
    logic [4:0]                dec_alu_op_i;
    logic [SHAMT_WIDTH-1:0]    dec_shamt_i;
    logic                      dec_invert_i;

    logic                      ex_valid_o;
    logic                      ex_ready_i;
    logic [DATA_WIDTH-1:0]     operands_a_o;
    logic [DATA_WIDTH-1:0]     operands_b_o;
    logic [4:0]                alu_op_o;
    logic [SHAMT_WIDTH-1:0]    shamt_o;
    logic                      invert_o;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_o;
    logic                      ex_rd_we_o;

    modport slave (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rd_we_i,
               dec_use_imm_i, dec_imm_i, dec_alu_op_i, dec_shamt_i, dec_invert_i,
               ex_ready_i,
        output dec_ready_o, ex_valid_o, operands_a_o, operands_b_o, alu_op_o,
               shamt_o, invert_o, ex_rd_o, ex_rd_we_o
    );

    modport master (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rd_we_i,
               dec_use_imm_i, dec_imm_i, dec_alu_op_i, dec_shamt_i, dec_invert_i,
               ex_ready_i,
        input  dec_ready_o, ex_valid_o, operands_a_o, operands_b_o, alu_op_o,
               shamt_o, invert_o, ex_rd_o, ex_rd_we_o
    );
endinterface

// File: rtl/core_issue.sv
// Operand-issue stage: register read with write-back forwarding, busy-bit
// scoreboard for RAW hazards, and a single registered slot towards execution.
module core_issue #(
    parameter int DATA_WIDTH     = 32,
    parameter int SHAMT_WIDTH    = 5,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    core_issue_if.slave               bus,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr_a_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr_b_o,
    input  logic [DATA_WIDTH-1:0]     rf_rdata_a_i,
    input  logic [DATA_WIDTH-1:0]     rf_rdata_b_i,
    input  logic                      wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic                      flush_i
);
    localparam int NREG = 2 ** REG_ADDR_WIDTH;

    logic [NREG-1:0]           busy_q, busy_d;
    logic                      ex_valid_q, ex_valid_d;
    logic [DATA_WIDTH-1:0]     a_q, b_q;
    logic [4:0]                op_q;
    logic [SHAMT_WIDTH-1:0]    shamt_q;
    logic                      inv_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      rd_we_q;

    logic                      wb_hit_a, wb_hit_b;
    logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;
    logic                      hazard, ready, accept;

    assign rf_raddr_a_o = bus.dec_rs1_i;
    assign rf_raddr_b_o = bus.dec_rs2_i;

    assign wb_hit_a = wb_valid_i && (wb_rd_i == bus.dec_rs1_i);
    assign wb_hit_b = wb_valid_i && (wb_rd_i == bus.dec_rs2_i);

    always_comb begin
        fwd_a = rf_rdata_a_i;
        fwd_b = rf_rdata_b_i;
        if (bus.dec_rs1_i == '0)  fwd_a = '0;
        else if (wb_hit_a)        fwd_a = wb_data_i;
        if (bus.dec_rs2_i == '0)  fwd_b = '0;
        else if (wb_hit_b)        fwd_b = wb_data_i;
    end

    // A source being written back this cycle is usable through forwarding.
    assign hazard = (busy_q[bus.dec_rs1_i] && !wb_hit_a) ||
                    (!bus.dec_use_imm_i && busy_q[bus.dec_rs2_i] && !wb_hit_b);
    assign ready  = !hazard && !flush_i && (!ex_valid_q || bus.ex_ready_i);
    assign accept = bus.dec_valid_i && ready;

    // Clears first, then the accept's set so it wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i)
            busy_d[wb_rd_i] = 1'b0;
        if (flush_i && ex_valid_q && rd_we_q)
            busy_d[rd_q] = 1'b0;
        if (accept && bus.dec_rd_we_i)
            busy_d[bus.dec_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (accept)
            ex_valid_d = 1'b1;
        else if (flush_i || (ex_valid_q && bus.ex_ready_i))
            ex_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            shamt_q    <= '0;
            inv_q      <= 1'b0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            if (accept) begin
                a_q     <= fwd_a;
                b_q     <= bus.dec_use_imm_i ? bus.dec_imm_i : fwd_b;
                op_q    <= bus.dec_alu_op_i;
                shamt_q <= bus.dec_shamt_i;
                inv_q   <= bus.dec_invert_i;
                rd_q    <= bus.dec_rd_i;
                rd_we_q <= bus.dec_rd_we_i;
            end
        end
    end

    assign bus.dec_ready_o  = ready;
    assign bus.ex_valid_o   = ex_valid_q;
    assign bus.operands_a_o = a_q;
    assign bus.operands_b_o = b_q;
    assign bus.alu_op_o     = op_q;
    assign bus.shamt_o      = shamt_q;
    assign bus.invert_o     = inv_q;
    assign bus.ex_rd_o      = rd_q;
    assign bus.ex_rd_we_o   = rd_we_q;
endmodule
